// File: rtl/pe_mac_if.sv
// Handshake bundle between the line-buffer/weight-fetch stage, the MAC PE
// and the activation stage.
interface pe_mac_if #(
    parameter int LANES = 4,
    parameter int PIC_W = 16,
    parameter int WGT_W = 16,
    parameter int CNT_W = 5,
    parameter int RES_W = 39
);
    logic [CNT_W-1:0]       cfg_taps;
    logic                   cfg_signed;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIC_W-1:0] pic_dat;
    logic [LANES*WGT_W-1:0] wgt_dat;
    logic                   out_valid;
    logic                   out_ready;
    logic [RES_W-1:0]       result;
    logic                   busy;

    modport master (
        output cfg_taps, cfg_signed, flush, in_valid, pic_dat, wgt_dat, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  cfg_taps, cfg_signed, flush, in_valid, pic_dat, wgt_dat, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/pe_mac_lanes.sv
// Convolution PE: LANES parallel multipliers summed into one accumulator per
// beat; one result per window of a runtime-configured number of taps.

module pe_mac_lane #(
    parameter int PIC_W = 16,
    parameter int WGT_W = 16,
    parameter int RES_W = 39
) (
    input  logic [PIC_W-1:0] pic,
    input  logic [WGT_W-1:0] wgt,
    input  logic             is_signed,
    output logic [RES_W-1:0] prod_ext
);
    localparam int PROD_W = PIC_W + WGT_W + 2;

    // One extra bit per operand lets a single signed multiplier serve both modes.
    logic signed [PIC_W:0]    a;
    logic signed [WGT_W:0]    b;
    logic signed [PROD_W-1:0] prod;

    assign a        = {is_signed & pic[PIC_W-1], pic};
    assign b        = {is_signed & wgt[WGT_W-1], wgt};
    assign prod     = PROD_W'(a) * PROD_W'(b);
    assign prod_ext = {{(RES_W-PROD_W){prod[PROD_W-1]}}, prod};
endmodule

module pe_mac_lanes #(
    parameter int LANES    = 4,
    parameter int PIC_W    = 16,
    parameter int WGT_W    = 16,
    parameter int MAX_TAPS = 25,
    parameter int CNT_W    = 5,
    parameter int RES_W    = 39
) (
    input  logic     clk,
    input  logic     rst,
    pe_mac_if.slave  bus
);
    logic [LANES-1:0][RES_W-1:0] prod;
    logic [RES_W-1:0]            beat_sum, acc_next, acc, result_q;
    logic [CNT_W-1:0]            tap_cnt, taps_q, cfg_eff, taps_eff;
    logic                        signed_q, eff_signed, out_valid_q;
    logic                        final_beat, accept, first_beat;

    assign first_beat = (tap_cnt == '0);
    assign eff_signed = first_beat ? bus.cfg_signed : signed_q;
    assign cfg_eff    = (bus.cfg_taps == '0)                 ? CNT_W'(1) :
                        (bus.cfg_taps > CNT_W'(MAX_TAPS))    ? CNT_W'(MAX_TAPS) :
                                                               bus.cfg_taps;
    assign taps_eff   = first_beat ? cfg_eff : taps_q;
    assign final_beat = (tap_cnt == taps_eff - CNT_W'(1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pe_mac_lane #(.PIC_W(PIC_W), .WGT_W(WGT_W), .RES_W(RES_W)) u_lane (
            .pic      (bus.pic_dat[g*PIC_W +: PIC_W]),
            .wgt      (bus.wgt_dat[g*WGT_W +: WGT_W]),
            .is_signed(eff_signed),
            .prod_ext (prod[g])
        );
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) beat_sum = beat_sum + prod[i];
    end

    assign acc_next = (first_beat ? '0 : acc) + beat_sum;

    // Only the window-closing beat needs the output register free.
    assign bus.in_ready = !rst && !bus.flush && (!out_valid_q || bus.out_ready || !final_beat);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt     <= '0;
            acc         <= '0;
            taps_q      <= CNT_W'(1);
            signed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (bus.flush) begin
                tap_cnt <= '0;
                acc     <= '0;
            end else if (accept) begin
                if (first_beat) begin
                    taps_q   <= cfg_eff;
                    signed_q <= bus.cfg_signed;
                end
                if (final_beat) begin
                    result_q    <= acc_next;
                    out_valid_q <= 1'b1;
                    tap_cnt     <= '0;
                    acc         <= '0;
                end else begin
                    acc     <= acc_next;
                    tap_cnt <= tap_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = !first_beat;
endmodule

// File: tb/tb_pe_mac_lanes.sv
// Bench for pe_mac_lanes: directed scenarios plus random traffic, all checked
// every cycle against a window-level arithmetic model.
module tb_pe_mac_lanes;
    localparam int LANES = 4, PIC_W = 16, WGT_W = 16, MAX_TAPS = 25, CNT_W = 5, RES_W = 39;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_mac_if #(.LANES(LANES), .PIC_W(PIC_W), .WGT_W(WGT_W), .CNT_W(CNT_W), .RES_W(RES_W)) bus ();

    pe_mac_lanes #(.LANES(LANES), .PIC_W(PIC_W), .WGT_W(WGT_W), .MAX_TAPS(MAX_TAPS),
                   .CNT_W(CNT_W), .RES_W(RES_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0, bad = 0;

    // model state
    int               m_cnt = 0, m_taps = 1, m_hs = 0, dut_hs = 0;
    logic             m_sgn = 1'b0, m_ov = 1'b0, m_fired = 1'b0;
    logic [RES_W-1:0] m_acc = '0, m_res = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampf(input int t);
        return (t == 0) ? 1 : (t > MAX_TAPS) ? MAX_TAPS : t;
    endfunction

    function automatic logic [RES_W-1:0] beat_sum_f(input logic [63:0] p, input logic [63:0] w, input logic sgn);
        longint s, a, b;
        logic [15:0] pu, wu;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            pu = p[i*16 +: 16];
            wu = w[i*16 +: 16];
            a = sgn ? longint'($signed(pu)) : longint'(pu);
            b = sgn ? longint'($signed(wu)) : longint'(wu);
            s += a * b;
        end
        return s[RES_W-1:0];
    endfunction

    function automatic logic model_final();
        int t;
        t = (m_cnt == 0) ? clampf(int'(bus.cfg_taps)) : m_taps;
        return m_cnt == t - 1;
    endfunction

    function automatic logic model_rdy();
        return !rst && !bus.flush && (!m_ov || bus.out_ready || !model_final());
    endfunction

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    // reference model: window-level arithmetic on sampled inputs
    always @(posedge clk or posedge rst) begin
        logic fire, fin;
        logic [RES_W-1:0] nxt;
        if (rst) begin
            m_cnt = 0; m_taps = 1; m_sgn = 1'b0; m_acc = '0;
            m_ov = 1'b0; m_res = '0; m_fired = 1'b0;
        end else begin
            fire = bus.in_valid && model_rdy();
            fin  = model_final();
            nxt  = (m_cnt == 0 ? '0 : m_acc) +
                   beat_sum_f(bus.pic_dat, bus.wgt_dat, (m_cnt == 0) ? bus.cfg_signed : m_sgn);
            if (m_ov && bus.out_ready) begin m_ov = 1'b0; m_hs++; end
            if (bus.flush) begin
                m_cnt = 0; m_acc = '0;
            end else if (fire) begin
                if (m_cnt == 0) begin m_taps = clampf(int'(bus.cfg_taps)); m_sgn = bus.cfg_signed; end
                if (fin) begin m_res = nxt; m_ov = 1'b1; m_cnt = 0; m_acc = '0; end
                else begin m_acc = nxt; m_cnt++; end
            end
            m_fired = fire;
        end
    end

    always @(posedge clk) if (!rst && bus.out_valid && bus.out_ready) dut_hs++;

    always @(negedge clk) begin
        chk("in_ready",  64'(bus.in_ready),  64'(model_rdy()));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("busy",      64'(bus.busy),      64'(m_cnt != 0));
        chk("result",    64'(bus.result),    64'(m_res));
    end

    task automatic beat(input logic [63:0] p, input logic [63:0] w, output int waited);
        bus.pic_dat = p; bus.wgt_dat = w; bus.in_valid = 1'b1; waited = 0;
        do begin @(posedge clk); #1; waited++; end while (!m_fired && waited < 50);
        bus.in_valid = 1'b0;
        if (!m_fired) chk("beat_timeout", 64'(m_fired), 64'd1);
    endtask

    task automatic beats(input int n, input logic [15:0] p, input logic [15:0] w, output int cyc);
        int wt;
        cyc = 0;
        for (int i = 0; i < n; i++) begin beat(rep(p), rep(w), wt); cyc += wt; end
    endtask

    task automatic expect_res(input string nm, input logic [RES_W-1:0] v);
        chk({nm, "_ov"},  64'(bus.out_valid), 64'd1);
        chk({nm, "_dut"}, 64'(bus.result),    64'(v));
        chk({nm, "_mdl"}, 64'(m_res),         64'(v));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, wt;
        bus.cfg_taps = '0; bus.cfg_signed = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.pic_dat = '0; bus.wgt_dat = '0; bus.out_ready = 1'b1;
        idle(3);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        idle(1);

        // 1: unsigned taps=5, back-to-back windows
        bus.cfg_taps = 5;
        beats(5, 16'd1, 16'd1, cyc);
        expect_res("t1a", 39'd20);
        beats(5, 16'd1, 16'd1, wt);
        expect_res("t1b", 39'd20);
        chk("t1_no_bubbles", 64'(cyc + wt), 64'd10);
        idle(2);

        // 2: signed vs unsigned on the same operands
        bus.cfg_taps = 3; bus.cfg_signed = 1'b1;
        beats(3, 16'hFFFF, 16'd2, cyc);
        expect_res("t2s", 39'h7FFFFFFFE8);
        bus.cfg_signed = 1'b0;
        beats(3, 16'hFFFF, 16'd2, cyc);
        expect_res("t2u", 39'd1572840);
        idle(2);

        // 3: backpressure on the final beat only
        bus.cfg_taps = 2;
        beats(2, 16'd1, 16'd1, cyc);
        expect_res("t3a", 39'd8);
        bus.out_ready = 1'b0;
        beat(rep(16'd3), rep(16'd1), wt);
        chk("t3_first_beat_flows", 64'(wt), 64'd1);
        bus.pic_dat = rep(16'd3); bus.in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t3_stall_ready", 64'(bus.in_ready), 64'd0);
            chk("t3_stall_fire", 64'(m_fired), 64'd0);
            expect_res("t3_hold", 39'd8);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("t3_handover_fire", 64'(m_fired), 64'd1);
        expect_res("t3b", 39'd24);
        idle(2);

        // 4: taps=0 -> 1, taps=31 -> 25, mid-window config ignored
        bus.cfg_taps = 0;
        for (int i = 1; i <= 3; i++) begin
            beat(rep(16'(i)), rep(16'd1), wt);
            expect_res("t4_taps0", 39'(4 * i));
        end
        idle(2);
        bus.cfg_taps = 31;
        beats(24, 16'd1, 16'd1, cyc);
        chk("t4_clamp_not_early", 64'(bus.out_valid), 64'd0);
        beats(1, 16'd1, 16'd1, cyc);
        expect_res("t4_clamp", 39'd100);
        idle(2);
        bus.cfg_taps = 3; bus.cfg_signed = 1'b0;
        beats(1, 16'd1, 16'd1, cyc);
        bus.cfg_taps = 5; bus.cfg_signed = 1'b1;
        beats(2, 16'hFFFF, 16'd1, cyc);
        expect_res("t4_midcfg", 39'd524284);
        bus.cfg_signed = 1'b0;
        idle(2);

        // 5: flush drops the partial window
        bus.cfg_taps = 5;
        beats(3, 16'd1, 16'd1, cyc);
        chk("t5_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("t5_flush_no_fire", 64'(m_fired), 64'd0);
        chk("t5_busy_after", 64'(bus.busy), 64'd0);
        beats(4, 16'd2, 16'd3, cyc);
        chk("t5_no_early", 64'(bus.out_valid), 64'd0);
        beats(1, 16'd2, 16'd3, cyc);
        expect_res("t5", 39'd120);
        idle(2);

        // 6: full-scale window, then async reset mid-window during a stall
        bus.cfg_taps = 25;
        beats(25, 16'hFFFF, 16'hFFFF, cyc);
        expect_res("t6_max", 39'd429483622500);
        bus.out_ready = 1'b0;
        bus.cfg_taps = 5;
        beats(2, 16'd1, 16'd1, cyc);
        chk("t6_stalled_ov", 64'(bus.out_valid), 64'd1);
        chk("t6_busy_pre", 64'(bus.busy), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_ov", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_res", 64'(bus.result), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1; bus.cfg_taps = 1;
        beat(rep(16'd1), rep(16'd5), wt);
        expect_res("t6_after_rst", 39'd20);
        idle(2);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.cfg_taps   = ($urandom_range(0, 1) != 0) ? CNT_W'($urandom_range(0, 4)) : CNT_W'($urandom_range(0, 31));
            bus.cfg_signed = 1'($urandom_range(0, 1));
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.pic_dat    = {$urandom, $urandom};
            bus.wgt_dat    = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        idle(3);
        chk("handshake_count", 64'(dut_hs), 64'(m_hs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
